operand_loader: RTL

//  Producer/sequencer for the 4-operand (A+B)-(C+D) datapath: accepts a nibble stream on a

---
 rtl/operand_loader_pkg.sv | 15 +
 rtl/operand_loader_idx_decoder.sv | 17 +
 rtl/operand_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader and the (A+B)-(C+D) datapath it feeds.
package operand_loader_pkg;

    localparam int DP_OP_W  = 4;
    localparam int DP_RES_W = 5;
    localparam int NUM_OPS  = 4;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2,
        ST_CLEAR  = 2'd3
    } state_e;

endpackage

// File: rtl/operand_loader_idx_decoder.sv
// Turns the operand slot index plus an accept strobe into the one-hot datapath store enable.
module operand_loader_idx_decoder
    import operand_loader_pkg::*;
(
    input  logic [1:0]         idx,
    input  logic               strobe,
    output logic [NUM_OPS-1:0] en
);

    always_comb begin
        en = '0;
        if (strobe) begin
            en[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Sequences four nibbles into the datapath operand slots, waits for the full flag,
// hands the result downstream, then clears the datapath store flags.
//
// state     | meaning
// ST_LOAD   | accepting nibbles, steering each into slot A..D
// ST_WAIT   | all four stored, waiting (bounded) for dp_full
// ST_RESULT | out_valid held until downstream accepts
// ST_CLEAR  | one-cycle dp_clear pulse before the next set
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int OP_W     = DP_OP_W,
    parameter int RES_W    = DP_RES_W,
    parameter int WAIT_MAX = 3
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [OP_W-1:0]    in_data,
    output logic               in_ready,
    output logic [OP_W-1:0]    dp_d_in,
    output logic [NUM_OPS-1:0] dp_en,
    output logic               dp_clear,
    input  logic               dp_full,
    input  logic [RES_W-1:0]   dp_result,
    output logic               out_valid,
    output logic [RES_W-1:0]   out_data,
    input  logic               out_ready,
    input  logic               abort,
    output logic               err
);

    localparam logic [1:0] WAIT_LAST = 2'(WAIT_MAX - 1);
    localparam logic [1:0] IDX_LAST  = 2'(NUM_OPS - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       wait_cnt_q, wait_cnt_d;
    logic [RES_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic             accept;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        dp_clear    = 1'b0;
        accept      = 1'b0;

        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d    = ST_WAIT;
                        idx_d      = 2'd0;
                        wait_cnt_d = 2'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (dp_full) begin
                    out_data_d  = dp_result;
                    out_valid_d = 1'b1;
                    wait_cnt_d  = 2'd0;
                    state_d     = ST_RESULT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Datapath never reported full: flag it and drop this set.
                    err_d      = 1'b1;
                    wait_cnt_d = 2'd0;
                    state_d    = ST_CLEAR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                dp_clear = 1'b1;
                idx_d    = 2'd0;
                state_d  = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase

        // Abort overrides whatever the state decided, including a pending accept or handshake.
        if (abort && state_q != ST_CLEAR) begin
            state_d     = ST_CLEAR;
            idx_d       = 2'd0;
            wait_cnt_d  = 2'd0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            err_d       = err_q;
            in_ready    = 1'b0;
            accept      = 1'b0;
        end

        if (rst) begin
            in_ready = 1'b0;
            dp_clear = 1'b0;
            accept   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= 2'd0;
            wait_cnt_q  <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    operand_loader_idx_decoder u_idx_decoder (
        .idx    (idx_q),
        .strobe (accept),
        .en     (dp_en)
    );

    assign dp_d_in   = in_data;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule
